stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
Parametrised synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides. It stores entries in a registered-read dual-port RAM and adds one output stage. It is the standard elastic buffer between encoder pipeline stages (e.g. DCT → quantiser → Huffman packer), with a synchronous flush for frame boundaries. Sustains 1 transfer/cycle in and out simultaneously.

Parameters:
WIDTH, 8, data bit width (≥1)
DEPTH, 1024, RAM entries; power of two, ≥4
AF_THRESH, DEPTH-2, almost-full threshold on level; used only with the level feature

Ports:
clk  input  1  clock
n_rst  input  1  synchronous active-low reset
flush  input  1  synchronous clear of all contents; does not reset RAM array contents
in_valid  input  1  write request
in_ready  output  1  FIFO can accept
in_data  input  WIDTH  write data
out_valid  output  1  out_data holds an entry
out_ready  input  1  consumer accepts
out_data  output  WIDTH  head entry; equals the RAM read register
level  output  $clog2(DEPTH+2)  occupancy 0..DEPTH+1 (only with STREAM_FIFO_LEVEL_EN)
almost_full  output  1  level ≥ AF_THRESH (only with STREAM_FIFO_LEVEL_EN)

Behaviour:
- Reset (n_rst=0 at posedge): wptr=rptr=0, out_valid=0, out_data=0, in_ready=0 while n_rst low; in_ready=1 from first cycle after release.
- Pointers: ADDR_W=$clog2(DEPTH); wptr/rptr are ADDR_W+1 bits with a wrap bit. ram_count=wptr-rptr, modulo 2^(ADDR_W+1). ram_empty: ptrs equal. ram_full: ptrs equal in address bits, wrap bits differ.
- in_ready = !ram_full && n_rst, driven from registers only, with no combinational path from out_ready. Write fires when in_valid && in_ready: RAM[wptr] <= in_data; wptr++.
- Read stage: advance = !out_valid || out_ready. If advance && !ram_empty: issue RAM re at rptr, rptr++, out_valid<=1. If advance && ram_empty: out_valid<=0. If !advance: hold; re=0 so out_data is stable.
- out_data/out_valid stay stable while out_valid && !out_ready (AXI-style hold).
- Latency: word accepted at edge k into an empty FIFO gives out_valid=1 in the cycle after edge k+1. There is no write-to-output bypass.
- Capacity: DEPTH+1 entries (DEPTH in RAM + 1 in output stage).
- Simultaneous write and read when ram_full: write refused (in_ready=0) that cycle; the read proceeds, and in_ready rises the next cycle.
- Simultaneous write and read when ram_count=1 and advance: the read takes the old entry, the write lands in RAM, and ram_count stays 1.
- Wrap-around: pointer address bits wrap at DEPTH. The wrap bit toggles and data order is preserved.
- flush=1 at posedge: wptr=rptr=0, out_valid=0. A concurrent write is dropped, and in_ready stays as computed. out_data is not cleared. flush has priority over all operations. n_rst has priority over flush.
- Reset mid-operation: all entries discarded. No output pulse.

Optional Feature:
STREAM_FIFO_LEVEL_EN
- Defined: adds the level and almost_full ports. level = ram_count + out_valid, registered-derived with no combinational input paths. almost_full = (level ≥ AF_THRESH). Both are 0 in reset and after flush.
- Undefined: neither port exists; AF_THRESH is unused; no counter logic is synthesised.

Decomposition:
- Shared package (jpeg_pkg): clog2-derived width constant helper, and common stream-width localparams (pixel 8, coef 12), for instantiating sites.
- Sub-module: storage is the existing dpram (FIFO_SIZE=DEPTH, BIT_WIDTH=WIDTH), instantiated once; re/raddr come from the read stage, we/waddr from the write side.
- All pointer, handshake and level logic lives in stream_fifo.

Test Plan:
- Fill: DEPTH=4, out_ready=0, write 0x11..0x15 → five accepted, in_ready=0 after the 5th, level=5; the 6th write is held.
- Latency: single write of 0xA5 at edge k into an empty FIFO → out_valid=1 after edge k+1 with out_data=0xA5; out_valid=0 the cycle after it is consumed.
- Streaming: in_valid=out_ready=1 continuously, 3·DEPTH words of an incrementing pattern → output in order with no bubbles after the first word, and pointers wrap at least twice.
- Backpressure: out_ready toggled pseudo-randomly during streaming → out_data is stable whenever out_valid && !out_ready; no loss or duplication against a scoreboard.
- Flush: 3 entries stored, flush plus concurrent write of 0x77 → next cycle out_valid=0, level=0, and 0x77 never appears.
- Reset mid-stream: n_rst=0 for 1 cycle with 2 entries queued → out_valid=0, out_data=0, in_ready=0 during reset and 1 after; a subsequent write of 0x3C appears as the first output.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared constants for the encoder pipeline: stream widths and a width helper
// used when sizing pointers and counters at instantiating sites.
package jpeg_pkg;

    localparam int PIXEL_W = 8;
    localparam int COEF_W  = 12;

    // Bits needed to index n distinct values; never less than one.
    function automatic int width_for(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register clears on reset; the array itself is never cleared.
module dpram #(
    parameter int FIFO_SIZE = 1024,
    parameter int BIT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         we,
    input  logic [$clog2(FIFO_SIZE)-1:0] waddr,
    input  logic [BIT_WIDTH-1:0]         wdata,
    input  logic                         re,
    input  logic [$clog2(FIFO_SIZE)-1:0] raddr,
    output logic [BIT_WIDTH-1:0]         rdata
);

    logic [BIT_WIDTH-1:0] mem [FIFO_SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO: dpram storage plus one output stage, giving
// DEPTH+1 entries. Optional level/almost_full ports with STREAM_FIFO_LEVEL_EN.
module stream_fifo
    import jpeg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 1024,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data
`ifdef STREAM_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+2)-1:0]   level,
    output logic                         almost_full
`endif
);

    localparam int ADDR_W = width_for(DEPTH);
    localparam logic [ADDR_W:0] PTR_INC = 1;

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic            ram_empty;
    logic            ram_full;
    logic            advance;
    logic            wr_fire;
    logic            rd_fire;

    assign ram_empty = (wptr == rptr);
    assign ram_full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) &&
                       (wptr[ADDR_W] != rptr[ADDR_W]);

    // Depends only on pointer registers and reset, never on out_ready.
    assign in_ready = n_rst && !ram_full;

    assign advance = !out_valid || out_ready;
    assign wr_fire = in_valid && in_ready && !flush;
    // A read during flush would disturb out_data, which flush must leave intact.
    assign rd_fire = advance && !ram_empty && !flush;

    always_ff @(posedge clk) begin
        if (!n_rst || flush) begin
            wptr      <= '0;
            rptr      <= '0;
            out_valid <= 1'b0;
        end else begin
            if (wr_fire) begin
                wptr <= wptr + PTR_INC;
            end
            if (advance) begin
                if (!ram_empty) begin
                    rptr      <= rptr + PTR_INC;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    dpram #(
        .FIFO_SIZE (DEPTH),
        .BIT_WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .n_rst (n_rst),
        .we    (wr_fire),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata (in_data),
        .re    (rd_fire),
        .raddr (rptr[ADDR_W-1:0]),
        .rdata (out_data)
    );

`ifdef STREAM_FIFO_LEVEL_EN
    localparam int LVL_W = width_for(DEPTH + 2);
    localparam logic [LVL_W-1:0] LVL_ONE = 1;
    localparam logic [LVL_W-1:0] AF_LVL  = LVL_W'(AF_THRESH);

    logic [LVL_W-1:0] level_nxt;
    logic             pop;

    // Moving an entry from RAM to the output stage leaves the total unchanged.
    assign pop = out_valid && out_ready;

    always_comb begin
        level_nxt = level;
        case ({wr_fire, pop})
            2'b10:   level_nxt = level + LVL_ONE;
            2'b01:   level_nxt = level - LVL_ONE;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst || flush) begin
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            level       <= level_nxt;
            almost_full <= (level_nxt >= AF_LVL);
        end
    end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo at DEPTH=4: fill, latency, streaming,
// random backpressure, flush and mid-stream reset.
module tb_stream_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             n_rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef STREAM_FIFO_LEVEL_EN
    logic [$clog2(DEPTH+2)-1:0] level;
    logic                       almost_full;
`endif

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
`ifdef STREAM_FIFO_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [WIDTH-1:0] sb[$];
    int               tx_cnt = 0;
    int               rx_cnt = 0;
    logic             hold_pend = 1'b0;
    logic [WIDTH-1:0] hold_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_level(input string tag, input int exp_lvl, input logic exp_af);
`ifdef STREAM_FIFO_LEVEL_EN
        check({tag, "_level"}, 32'(level), 32'(exp_lvl));
        check({tag, "_af"}, 32'(almost_full), 32'(exp_af));
`else
        if (tag.len() < 0 || exp_lvl < 0 || exp_af) begin
        end
`endif
    endtask

    // Drive one cycle, sample #1 later, score handshakes, then go to the next negedge.
    task automatic cyc(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
        logic [WIDTH-1:0] exp;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (hold_pend) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(hold_data));
        end
        if (!n_rst || fl) begin
            sb.delete();
            hold_pend = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                tx_cnt++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("pop_with_empty_sb", 32'(sb.size()), 32'd1);
                end else begin
                    exp = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(exp));
                    rx_cnt++;
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int c = 0; c < 64; c++) begin
            if (sb.size() == 0 && !out_valid) break;
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain_done", 32'(sb.size() == 0 && !out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx0;
        int rx0;
        int bubbles;
        logic seen;
        logic iv;

        n_rst     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check_level("rst", 0, 1'b0);
        n_rst = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Fill to DEPTH+1 with the consumer stalled
        tx0 = tx_cnt;
        for (int i = 0; i < 5; i++) cyc(1'b1, WIDTH'(8'h11 + i), 1'b0, 1'b0);
        check("fill_accepted", 32'(tx_cnt - tx0), 32'd5);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_out_data", 32'(out_data), 32'h11);
        check_level("fill", 5, 1'b1);
        cyc(1'b1, 8'h16, 1'b0, 1'b0);
        check("fill_6th_held", 32'(tx_cnt - tx0), 32'd5);
        drain();
        check_level("fill_drained", 0, 1'b0);

        // Latency into an empty FIFO
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        check("lat_after_k", 32'(out_valid), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("lat_after_k1_valid", 32'(out_valid), 32'd1);
        check("lat_after_k1_data", 32'(out_data), 32'hA5);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("lat_consumed", 32'(out_valid), 32'd0);

        // Full-rate streaming, 3*DEPTH words
        tx0 = tx_cnt; rx0 = rx_cnt; bubbles = 0; seen = 1'b0;
        for (int c = 0; c < 60 && (rx_cnt - rx0) < 3 * DEPTH; c++) begin
            if (seen && !out_valid && (rx_cnt - rx0) < 3 * DEPTH) bubbles++;
            if (out_valid) seen = 1'b1;
            iv = (tx_cnt - tx0) < 3 * DEPTH;
            cyc(iv, WIDTH'(8'h80 + (tx_cnt - tx0)), 1'b1, 1'b0);
        end
        check("stream_count", 32'(rx_cnt - rx0), 32'(3 * DEPTH));
        check("stream_bubbles", 32'(bubbles), 32'd0);
        drain();

        // Random backpressure
        tx0 = tx_cnt; rx0 = rx_cnt;
        for (int c = 0; c < 400 && (rx_cnt - rx0) < 40; c++) begin
            iv = ((tx_cnt - tx0) < 40) && ($urandom_range(3) != 0);
            cyc(iv, WIDTH'($urandom_range(255)), 1'($urandom_range(1)), 1'b0);
        end
        check("bp_count", 32'(rx_cnt - rx0), 32'd40);
        drain();

        // Flush with a concurrent write
        cyc(1'b1, 8'h21, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h23, 1'b0, 1'b0);
        check_level("pre_flush", 3, 1'b1);
        cyc(1'b1, 8'h77, 1'b0, 1'b1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_keeps_data", 32'(out_data), 32'h21);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check_level("flush", 0, 1'b0);
        cyc(1'b1, 8'h31, 1'b0, 1'b0);
        drain();

        // Reset mid-stream with two entries queued
        cyc(1'b1, 8'h41, 1'b0, 1'b0);
        cyc(1'b1, 8'h42, 1'b0, 1'b0);
        n_rst = 1'b0;
        #1;
        check("mid_rst_in_ready_low", 32'(in_ready), 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check_level("mid_rst", 0, 1'b0);
        n_rst = 1'b1;
        #1;
        check("mid_rst_in_ready_rel", 32'(in_ready), 32'd1);
        rx0 = rx_cnt;
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        drain();
        check("mid_rst_one_output", 32'(rx_cnt - rx0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
